// File: rtl/free_list_ckpt_if.sv
// Allocate/free/checkpoint bundle between the free list and dispatch/retire.
interface free_list_ckpt_if #(
  parameter int TAG_W = 7,
  parameter int PTR_W = 6
);
  logic [1:0]       alloc_num;
  logic [TAG_W-1:0] alloc_tag_a;
  logic [TAG_W-1:0] alloc_tag_b;
  logic             alloc_ok;
  logic [1:0]       free_num;
  logic [TAG_W-1:0] free_tag_a;
  logic [TAG_W-1:0] free_tag_b;
  logic             ckpt_take;
  logic             restore;
  logic [PTR_W:0]   free_count;
  logic             empty;
  logic             err;

  // Dispatch/retire side: issues requests, consumes tags and status.
  modport master (
    output alloc_num, free_num, free_tag_a, free_tag_b, ckpt_take, restore,
    input  alloc_tag_a, alloc_tag_b, alloc_ok, free_count, empty, err
  );

  // Free list side.
  modport slave (
    input  alloc_num, free_num, free_tag_a, free_tag_b, ckpt_take, restore,
    output alloc_tag_a, alloc_tag_b, alloc_ok, free_count, empty, err
  );
endinterface

// File: rtl/free_list_ckpt.sv
// Circular-FIFO free list of physical register tags, two-wide allocate and
// free, with occupancy count, all-or-nothing grant and a single head
// checkpoint for branch-mispredict recovery.
module free_list_ckpt #(
  parameter int PREG_NUM = 96,
  parameter int AREG_NUM = 32,
  parameter int DEPTH    = 64,
  parameter int TAG_W    = 7,
  parameter int PTR_W    = 6
) (
  input  logic             clock,
  input  logic             reset,
  free_list_ckpt_if.slave  bus
);
  localparam int CNT_W = PTR_W + 1;

  // Pointers carry a wrap bit on top of the index bits.
  logic [CNT_W-1:0] head_reg, tail_reg, ckpt_reg, count_reg;
  logic             err_reg;

  logic [CNT_W-1:0] head_next, tail_next, count_next;
  logic [CNT_W:0]   proj_count;
  logic [1:0]       grant, free_req, free_acc;
  logic             alloc_bad, free_bad, alloc_ok, overflow;

  logic [TAG_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0] head_idx, head_idx_b, tail_idx, tail_idx_b;

  assign head_idx   = head_reg[PTR_W-1:0];
  assign head_idx_b = head_idx + 1'b1;
  assign tail_idx   = tail_reg[PTR_W-1:0];
  assign tail_idx_b = tail_idx + 1'b1;

  // Grant decision, pointer and count updates, overflow detection.
  always_comb begin
    alloc_bad  = (bus.alloc_num == 2'd3);
    free_bad   = (bus.free_num == 2'd3);
    alloc_ok   = !alloc_bad && !bus.restore &&
                 (CNT_W'(bus.alloc_num) <= count_reg);
    grant      = alloc_ok ? bus.alloc_num : 2'd0;
    free_req   = free_bad ? 2'd0 : bus.free_num;
    // Restore rolls head back and suppresses this cycle's allocation.
    head_next  = bus.restore ? ckpt_reg : head_reg + CNT_W'(grant);
    // Occupancy if every requested free were accepted; one extra bit so
    // values above DEPTH are visible.
    proj_count = {1'b0, tail_reg - head_next} + (CNT_W+1)'(free_req);
    overflow   = proj_count > (CNT_W+1)'(DEPTH);
    free_acc   = overflow ? 2'd0 : free_req;
    tail_next  = tail_reg + CNT_W'(free_acc);
    count_next = tail_next - head_next;
  end

  // List storage: one register per slot, freed tags written at tail/tail+1.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Reset contents are the non-architectural tags, always below PREG_NUM.
      localparam logic [TAG_W-1:0] INIT_TAG = TAG_W'((AREG_NUM + gi) % PREG_NUM);
      logic [TAG_W-1:0] slot_reg;

      // Slot write from the first or second free lane.
      always_ff @(posedge clock) begin
        if (reset)
          slot_reg <= INIT_TAG;
        else if (free_acc != 2'd0 && tail_idx == PTR_W'(gi))
          slot_reg <= bus.free_tag_a;
        else if (free_acc == 2'd2 && tail_idx_b == PTR_W'(gi))
          slot_reg <= bus.free_tag_b;
      end

      assign entries[gi] = slot_reg;
    end
  endgenerate

  // Pointer, checkpoint, count and sticky error state.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= {1'b1, {PTR_W{1'b0}}};
      ckpt_reg  <= '0;
      count_reg <= CNT_W'(DEPTH);
      err_reg   <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      // Restore wins over a simultaneous take.
      if (!bus.restore && bus.ckpt_take)
        ckpt_reg <= head_next;
      if (alloc_bad || free_bad || overflow)
        err_reg <= 1'b1;
    end
  end

  assign bus.alloc_tag_a = entries[head_idx];
  assign bus.alloc_tag_b = entries[head_idx_b];
  assign bus.alloc_ok    = alloc_ok;
  assign bus.free_count  = count_reg;
  assign bus.empty       = (count_reg == '0);
  assign bus.err         = err_reg;
endmodule

// File: tb/tb_free_list_ckpt.sv
// Directed bench for free_list_ckpt: stimulus pushes expected responses into
// a scoreboard queue, a negedge monitor pops and compares.
module tb_free_list_ckpt;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  free_list_ckpt_if #(.TAG_W(7), .PTR_W(6)) bus ();

  free_list_ckpt #(
    .PREG_NUM(96), .AREG_NUM(32), .DEPTH(64), .TAG_W(7), .PTR_W(6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string nm;
    bit    mt;   // compare tags
    int    ta;
    int    tb;
    bit    mo;   // compare alloc_ok
    bit    ok;
    bit    mc;   // compare free_count and empty
    int    cnt;
    bit    mr;   // compare err
    bit    er;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void cmp(string nm, int act, int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
  endfunction

  function automatic void push_exp(string nm, bit mt, int ta, int tb, bit mo,
                                   bit ok, bit mc, int cnt, bit mr, bit er);
    exp_t e;
    e.nm = nm; e.mt = mt; e.ta = ta; e.tb = tb; e.mo = mo; e.ok = ok;
    e.mc = mc; e.cnt = cnt; e.mr = mr; e.er = er;
    sb.push_back(e);
  endfunction

  // Monitor: compare whatever the stimulus queued for this cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %s tag_a=%0d tag_b=%0d ok=%0d count=%0d empty=%0d err=%0d",
                 e.nm, bus.alloc_tag_a, bus.alloc_tag_b, bus.alloc_ok,
                 bus.free_count, bus.empty, bus.err);
        if (e.mt) begin
          cmp({e.nm, ".tag_a"}, int'(bus.alloc_tag_a), e.ta);
          cmp({e.nm, ".tag_b"}, int'(bus.alloc_tag_b), e.tb);
        end
        if (e.mo) cmp({e.nm, ".alloc_ok"}, int'(bus.alloc_ok), int'(e.ok));
        if (e.mc) begin
          cmp({e.nm, ".free_count"}, int'(bus.free_count), e.cnt);
          cmp({e.nm, ".empty"}, int'(bus.empty), (e.cnt == 0) ? 1 : 0);
        end
        if (e.mr) cmp({e.nm, ".err"}, int'(bus.err), int'(e.er));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input int an, input int fn, input int fa, input int fb,
                       input bit ck, input bit rs);
    bus.alloc_num  = 2'(an);
    bus.free_num   = 2'(fn);
    bus.free_tag_a = 7'(fa);
    bus.free_tag_b = 7'(fb);
    bus.ckpt_take  = ck;
    bus.restore    = rs;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reset with busy inputs present to show that reset overrides them.
  task automatic do_reset;
    reset = 1'b1;
    drive(2, 2, 5, 6, 1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    do_reset();

    // Reset state, first allocation, fill to empty.
    push_exp("rst", 1, 32, 33, 1, 1, 1, 64, 1, 0); tick();
    drive(2, 0, 0, 0, 0, 0);
    push_exp("a2_first", 1, 32, 33, 1, 1, 1, 64, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    push_exp("a2_next", 1, 34, 35, 1, 1, 1, 62, 0, 0); tick();
    for (int i = 1; i < 32; i++) begin
      drive(2, 0, 0, 0, 0, 0);
      push_exp($sformatf("fill%0d", i), 1, 32 + 2*i, 33 + 2*i, 1, 1, 1, 64 - 2*i, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    push_exp("empty_a1", 1, 32, 33, 1, 0, 1, 0, 1, 0); tick();
    push_exp("empty_stable", 1, 32, 33, 1, 0, 1, 0, 1, 0); tick();
    // Free while empty: no same-cycle bypass.
    drive(2, 2, 40, 41, 0, 0);
    push_exp("free_nobypass", 1, 32, 33, 1, 0, 1, 0, 0, 0); tick();
    drive(2, 0, 0, 0, 0, 0);
    push_exp("free_avail", 1, 40, 41, 1, 1, 1, 2, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    push_exp("free_used", 0, 0, 0, 1, 1, 1, 0, 1, 0); tick();

    // Checkpoint and restore.
    do_reset();
    drive(2, 0, 0, 0, 1, 0);
    push_exp("ck_take", 1, 32, 33, 1, 1, 1, 64, 1, 0); tick();
    drive(2, 0, 0, 0, 0, 0);
    push_exp("ck_a2", 1, 34, 35, 1, 1, 1, 62, 0, 0); tick();
    drive(2, 0, 0, 0, 0, 1);
    push_exp("rs_cyc", 1, 36, 37, 1, 0, 1, 60, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    push_exp("rs_after", 1, 34, 35, 1, 1, 1, 62, 1, 0); tick();
    // Restore together with take: checkpoint must stay at head=2.
    drive(2, 0, 0, 0, 0, 0);
    push_exp("rs_re_a2", 1, 34, 35, 1, 1, 1, 62, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 1);
    push_exp("rs_ck_both", 1, 36, 37, 1, 0, 1, 60, 0, 0); tick();
    drive(2, 0, 0, 0, 0, 0);
    push_exp("rs_ck_a2", 1, 34, 35, 1, 1, 1, 62, 0, 0); tick();
    // Restore with a same-cycle free: free still lands.
    drive(0, 1, 77, 0, 0, 1);
    push_exp("rs_free", 1, 36, 37, 1, 0, 1, 60, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    push_exp("rs_free_after", 1, 34, 35, 1, 1, 1, 63, 1, 0); tick();

    // Overflow at full: free dropped, err set.
    do_reset();
    drive(0, 1, 50, 0, 0, 0);
    push_exp("ovf_cyc", 1, 32, 33, 1, 1, 1, 64, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    push_exp("ovf_after", 1, 32, 33, 1, 1, 1, 64, 1, 1); tick();
    push_exp("ovf_sticky", 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();

    // Illegal alloc_num=3.
    do_reset();
    push_exp("rst_clears_err", 0, 0, 0, 0, 0, 1, 64, 1, 0); tick();
    drive(3, 0, 0, 0, 0, 0);
    push_exp("a3_cyc", 1, 32, 33, 1, 0, 1, 64, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    push_exp("a3_after", 1, 32, 33, 1, 1, 1, 64, 1, 1); tick();

    // Illegal free_num=3 alongside a legal single allocation.
    do_reset();
    drive(1, 3, 1, 2, 0, 0);
    push_exp("f3_cyc", 1, 32, 33, 1, 1, 1, 64, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    push_exp("f3_after", 1, 33, 34, 1, 1, 1, 63, 1, 1); tick();

    // All-or-nothing grant near empty, tag_b wrapping the index.
    do_reset();
    for (int i = 0; i < 31; i++) begin
      drive(2, 0, 0, 0, 0, 0);
      push_exp($sformatf("aon%0d", i), 1, 32 + 2*i, 33 + 2*i, 1, 1, 1, 64 - 2*i, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    push_exp("aon_a1", 1, 94, 95, 1, 1, 1, 2, 1, 0); tick();
    drive(2, 0, 0, 0, 0, 0);
    push_exp("aon_deny", 1, 95, 32, 1, 0, 1, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    push_exp("aon_last", 1, 95, 32, 1, 1, 1, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    push_exp("aon_zero", 0, 0, 0, 1, 1, 1, 0, 1, 0); tick();

    // Wrap: steady alloc/free of the oldest outstanding tags.
    do_reset();
    drive(2, 0, 0, 0, 0, 0);
    push_exp("wr_first", 1, 32, 33, 1, 1, 1, 64, 0, 0); tick();
    for (int i = 0; i < 40; i++) begin
      drive(2, 2, 32 + ((2*i) % 64), 32 + ((2*i + 1) % 64), 0, 0);
      push_exp($sformatf("wrap%0d", i), 1, 32 + ((2*i + 2) % 64),
               32 + ((2*i + 3) % 64), 1, 1, 1, 62, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    push_exp("wr_end", 1, 32 + (82 % 64), 32 + (83 % 64), 1, 1, 1, 62, 1, 0); tick();

    if (sb.size() != 0) cmp("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
